// File: rtl/dram_rd_pkg.sv
// Shared types for the strided DRAM read engine.
// Holds the engine state encoding.
package dram_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dram_rd_fifo.sv
// First-word-fall-through FIFO holding whole DRAM words.
// rd_data shows the head entry whenever empty is low.
module dram_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign wr_ok   = wr_en && (count != CW'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/dram_rd_stride.sv
// Strided DRAM reader: issues credit-limited requests,
// buffers responses and unpacks them into narrow words.
module dram_rd_stride
  import dram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH    = 15,
  parameter int SIZE_WIDTH    = 17,
  parameter int STRIDE_WIDTH  = 8,
  parameter int OUTPUT_WIDTH  = 16,
  parameter int DATA_IN_WIDTH = 32,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     dram_clk,
  input  logic                     dram_rst,
  input  logic                     go,
  input  logic [ADDR_WIDTH-1:0]    start_addr,
  input  logic [SIZE_WIDTH-1:0]    size,
  input  logic [STRIDE_WIDTH-1:0]  stride,
  input  logic                     stall,
  input  logic                     rd_en,
  output logic                     valid,
  output logic [OUTPUT_WIDTH-1:0]  data,
  output logic                     done,
  output logic                     busy,
  input  logic                     dram_ready,
  output logic                     dram_rd_en,
  output logic [ADDR_WIDTH-1:0]    dram_rd_addr,
  input  logic [DATA_IN_WIDTH-1:0] dram_rd_data,
  input  logic                     dram_rd_valid
);

  localparam int RATIO      = DATA_IN_WIDTH / OUTPUT_WIDTH;
  localparam int RATIO_LOG2 = $clog2(RATIO);
  localparam int IW = (RATIO_LOG2 > 0) ? RATIO_LOG2 : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = CW + 1;

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic [STRIDE_WIDTH-1:0]   stride_q;
  logic [SIZE_WIDTH-1:0]     req_left;
  logic [SIZE_WIDTH-1:0]     out_left;
  logic [SIZE_WIDTH-1:0]     req_rem;
  logic [SIZE_WIDTH:0]       req_init;
  logic [CW-1:0]             outstanding;
  logic [CW-1:0]             fifo_count;
  logic [UW-1:0]             used;
  logic [IW-1:0]             slice;
  logic [DATA_IN_WIDTH-1:0]  fifo_dout;
  logic                      fifo_empty;
  logic                      accept;
  logic                      resp;
  logic                      pop;
  logic                      last;
  logic                      can_issue;

  assign accept   = dram_rd_en && dram_ready;
  assign resp     = dram_rd_valid && (outstanding != '0);
  assign valid    = !fifo_empty;
  assign pop      = rd_en && valid;
  assign last     = (slice == IW'(RATIO - 1))
                 || (out_left == SIZE_WIDTH'(1));
  assign data     = valid
    ? fifo_dout[int'(slice)*OUTPUT_WIDTH +: OUTPUT_WIDTH]
    : '0;
  assign req_init = ({1'b0, size} + (SIZE_WIDTH+1)'(RATIO - 1))
                 >> RATIO_LOG2;
  assign req_rem  = req_left - SIZE_WIDTH'(accept);

  // The asserted request already owns a credit, pops are ignored.
  assign used = UW'(fifo_count) + UW'(outstanding)
              + UW'(dram_rd_en);
  assign can_issue = (state == ST_ACTIVE) && (req_rem != '0)
                  && !stall && (used < UW'(FIFO_DEPTH));

  dram_rd_fifo #(
    .WIDTH (DATA_IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (dram_clk),
    .rst     (dram_rst),
    .wr_en   (resp),
    .wr_data (dram_rd_data),
    .rd_en   (pop && last),
    .rd_data (fifo_dout),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      dram_rd_en   <= 1'b0;
      dram_rd_addr <= '0;
      next_addr    <= '0;
      stride_q     <= '0;
      req_left     <= '0;
      out_left     <= '0;
      outstanding  <= '0;
      slice        <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(resp);
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (go && size == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (go) begin
            state        <= ST_ACTIVE;
            busy         <= 1'b1;
            done         <= 1'b0;
            stride_q     <= stride;
            slice        <= '0;
            out_left     <= size;
            req_left     <= SIZE_WIDTH'(req_init);
            dram_rd_en   <= !stall;
            dram_rd_addr <= start_addr;
            next_addr    <= stall ? start_addr
              : start_addr + ADDR_WIDTH'(stride);
          end
        end
        ST_ACTIVE: begin
          if (accept) req_left <= req_rem;
          if (!dram_rd_en || dram_ready) begin
            dram_rd_en <= can_issue;
            if (can_issue) begin
              dram_rd_addr <= next_addr;
              next_addr    <= next_addr
                + ADDR_WIDTH'(stride_q);
            end
          end
          if (pop) begin
            out_left <= out_left - SIZE_WIDTH'(1);
            slice    <= last ? '0 : slice + IW'(1);
            if (out_left == SIZE_WIDTH'(1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_rd_stride.sv
// Self-checking bench: vector table, random transfers
// and hand-driven stall/reset sequences vs a reference model.
module tb_dram_rd_stride;

  localparam int AW = 15;
  localparam int SW = 17;
  localparam int TW = 8;
  localparam int OW = 16;
  localparam int DW = 32;
  localparam int FD = 16;
  localparam int R  = DW / OW;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [AW-1:0] start_addr;
  logic [SW-1:0] size;
  logic [TW-1:0] stride;
  logic          stall;
  logic          rd_en;
  logic          valid;
  logic [OW-1:0] data;
  logic          done;
  logic          busy;
  logic          dram_ready;
  logic          dram_rd_en;
  logic [AW-1:0] dram_rd_addr;
  logic [DW-1:0] dram_rd_data;
  logic          dram_rd_valid;

  always #5 clk = ~clk;

  dram_rd_stride dut (
    .dram_clk      (clk),
    .dram_rst      (rst),
    .go            (go),
    .start_addr    (start_addr),
    .size          (size),
    .stride        (stride),
    .stall         (stall),
    .rd_en         (rd_en),
    .valid         (valid),
    .data          (data),
    .done          (done),
    .busy          (busy),
    .dram_ready    (dram_ready),
    .dram_rd_en    (dram_rd_en),
    .dram_rd_addr  (dram_rd_addr),
    .dram_rd_data  (dram_rd_data),
    .dram_rd_valid (dram_rd_valid)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  typedef struct {
    int s; int sz; int st; int nreq;
    int a0; int a1; int a2;
    int rd; int rdy; int stl; int gm;
  } vec_t;

  int          acc_q[$];
  logic [15:0] out_q[$];
  rsp_t        rsp_q[$];
  int          salt;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic [31:0] dram_word(input int a,
                                            input int s);
    logic [31:0] x;
    x = 32'(a) * 32'h0001_9E37 + 32'(s);
    return x ^ {16'(a), 16'(s)};
  endfunction

  function automatic int exp_addr(input int s, input int st,
                                  input int k);
    return (s + k * st) % (1 << AW);
  endfunction

  function automatic logic [15:0] exp_out(input int s,
      input int st, input int sl, input int i);
    logic [31:0] w;
    w = dram_word(exp_addr(s, st, i / R), sl);
    return 16'(w >> (OW * (i % R)));
  endfunction

  task automatic run_xfer(input int s, input int sz,
      input int st, input int rd_pct, input int rdy_pct,
      input int stl_pct, input int hold, input int go_mid,
      output int viol, output int hold_acc,
      output bit finished);
    bit          held;
    bit          prev_stall;
    logic [AW-1:0] held_addr;
    int          last_due;
    int          due;
    acc_q.delete();
    out_q.delete();
    rsp_q.delete();
    viol = 0;
    hold_acc = 0;
    finished = 1'b0;
    held = 1'b0;
    prev_stall = 1'b0;
    held_addr = '0;
    last_due = 0;
    salt = int'($urandom_range(0, 65535));
    start_addr = AW'(s);
    size = SW'(sz);
    stride = TW'(st);
    stall = 1'b0;
    rd_en = 1'b0;
    dram_ready = 1'b0;
    dram_rd_valid = 1'b0;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rd_en = (cyc >= hold)
           && ($urandom_range(0, 99) < rd_pct);
      dram_ready = $urandom_range(0, 99) < rdy_pct;
      stall = $urandom_range(0, 99) < stl_pct;
      go = (go_mid != 0) && (cyc == 3);
      if (go) begin
        start_addr = AW'(s + 100);
        size = SW'(1);
        stride = TW'(st + 1);
      end
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        dram_rd_valid = 1'b1;
        dram_rd_data = rsp_q[0].d;
        void'(rsp_q.pop_front());
      end else begin
        dram_rd_valid = 1'b0;
        dram_rd_data = $urandom;
      end
      @(negedge clk);
      if (held && !(dram_rd_en && dram_rd_addr == held_addr))
        viol++;
      if (dram_rd_en && !held && prev_stall) viol++;
      held = dram_rd_en && !dram_ready;
      held_addr = dram_rd_addr;
      prev_stall = stall;
      if (dram_rd_en && dram_ready) begin
        acc_q.push_back(int'(dram_rd_addr));
        due = (cyc + 2 > last_due + 1) ? cyc + 2
                                       : last_due + 1;
        rsp_q.push_back('{due,
          dram_word(int'(dram_rd_addr), salt)});
        last_due = due;
      end
      if (rd_en && valid) out_q.push_back(data);
      if (cyc < hold) hold_acc = acc_q.size();
      if (acc_q.size() - out_q.size() / R > FD) viol++;
      if (done) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    go = 1'b0;
    rd_en = 1'b0;
    stall = 1'b0;
    dram_ready = 1'b0;
    dram_rd_valid = 1'b0;
  endtask

  task automatic verify(input string nm, input int s,
      input int sz, input int st, input int viol,
      input bit finished);
    int nreq;
    int bad_a;
    int bad_d;
    nreq = (sz + R - 1) / R;
    bad_a = 0;
    bad_d = 0;
    chk({nm, "_done"}, 64'(finished), 64'd1);
    chk({nm, "_nreq"}, 64'(acc_q.size()), 64'(nreq));
    chk({nm, "_nout"}, 64'(out_q.size()), 64'(sz));
    foreach (acc_q[k])
      if (acc_q[k] != exp_addr(s, st, k)) bad_a++;
    foreach (out_q[i])
      if (out_q[i] !== exp_out(s, st, salt, i)) bad_d++;
    chk({nm, "_addr_errs"}, 64'(bad_a), 64'd0);
    chk({nm, "_data_errs"}, 64'(bad_d), 64'd0);
    chk({nm, "_protocol"}, 64'(viol), 64'd0);
    chk({nm, "_end_flags"}, {61'd0, done, busy, valid},
        64'b100);
  endtask

  vec_t vt[6];
  int   viol;
  int   hacc;
  bit   fin;
  int   bad;
  int   rs;
  int   rz;
  int   rt;

  initial begin
    vt[0] = '{'h10, 6, 1, 3, 'h10, 'h11, 'h12,
              100, 100, 0, 0};
    vt[1] = '{'h7FFE, 5, 3, 3, 'h7FFE, 'h0001, 'h0004,
              100, 100, 0, 0};
    vt[2] = '{'h100, 1, 5, 1, 'h100, 0, 0,
              70, 60, 20, 0};
    vt[3] = '{'h20, 4, 0, 2, 'h20, 'h20, 0,
              50, 50, 30, 0};
    vt[4] = '{'h7FFF, 3, 'hFF, 2, 'h7FFF, 'h00FE, 0,
              60, 40, 20, 0};
    vt[5] = '{'h40, 30, 2, 15, 'h40, 'h42, 'h44,
              80, 80, 10, 1};

    rst = 1'b1;
    go = 1'b0;
    start_addr = '0;
    size = '0;
    stride = '0;
    stall = 1'b0;
    rd_en = 1'b0;
    dram_ready = 1'b0;
    dram_rd_data = '0;
    dram_rd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({valid, data, done, busy, dram_rd_en,
             dram_rd_addr}), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      run_xfer(vt[v].s, vt[v].sz, vt[v].st, vt[v].rd,
               vt[v].rdy, vt[v].stl, 0, vt[v].gm,
               viol, hacc, fin);
      verify($sformatf("vec%0d", v), vt[v].s, vt[v].sz,
             vt[v].st, viol, fin);
      chk($sformatf("vec%0d_tbl_nreq", v),
          64'(acc_q.size()), 64'(vt[v].nreq));
      if (acc_q.size() > 0)
        chk($sformatf("vec%0d_a0", v), 64'(acc_q[0]),
            64'(vt[v].a0));
      if (vt[v].nreq > 1 && acc_q.size() > 1)
        chk($sformatf("vec%0d_a1", v), 64'(acc_q[1]),
            64'(vt[v].a1));
      if (vt[v].nreq > 2 && acc_q.size() > 2)
        chk($sformatf("vec%0d_a2", v), 64'(acc_q[2]),
            64'(vt[v].a2));
    end

    // Consumer held off long enough for credits to run out.
    run_xfer('h200, 64, 1, 100, 100, 0, 100, 0,
             viol, hacc, fin);
    verify("backpressure", 'h200, 64, 1, viol, fin);
    chk("bp_credit_limit",
        64'(hacc <= FD && hacc > 0), 64'd1);

    for (int n = 0; n < 6; n++) begin
      rs = int'($urandom_range(0, (1 << AW) - 1));
      rz = int'($urandom_range(1, 40));
      rt = int'($urandom_range(0, 255));
      run_xfer(rs, rz, rt, 60, 60, 25, 0, 0,
               viol, hacc, fin);
      verify($sformatf("rand%0d", n), rs, rz, rt,
             viol, fin);
    end

    start_addr = AW'('h55);
    size = '0;
    stride = TW'(1);
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    chk("zero_size_flags", {62'd0, done, busy}, 64'b10);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      dram_ready = 1'b1;
      if (dram_rd_en) bad++;
      @(posedge clk);
      #1;
    end
    chk("zero_size_no_req", 64'(bad), 64'd0);

    start_addr = AW'('h300);
    size = SW'(20);
    stride = TW'(4);
    dram_ready = 1'b0;
    stall = 1'b0;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    chk("held_first", {47'd0, dram_rd_en, dram_rd_addr},
        {47'd0, 1'b1, 15'h300});
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      stall = (i >= 1 && i <= 3);
      @(posedge clk);
      #1;
      if (!(dram_rd_en && dram_rd_addr == AW'('h300)))
        bad++;
    end
    chk("held_stable", 64'(bad), 64'd0);
    dram_ready = 1'b1;
    stall = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_blocks_1", 64'(dram_rd_en), 64'd0);
    @(posedge clk);
    #1;
    chk("stall_blocks_2", 64'(dram_rd_en), 64'd0);
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("after_stall_req", {47'd0, dram_rd_en, dram_rd_addr},
        {47'd0, 1'b1, 15'h304});
    repeat (2) @(posedge clk);
    #1;
    dram_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_outputs",
        64'({valid, data, done, busy, dram_rd_en,
             dram_rd_addr}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dram_rd_valid = 1'b1;
      dram_rd_data = $urandom;
      @(posedge clk);
      #1;
    end
    dram_rd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("stale_ignored",
        {60'd0, valid, busy, done, dram_rd_en}, 64'd0);

    run_xfer('h1234, 9, 7, 90, 90, 10, 0, 0,
             viol, hacc, fin);
    verify("post_reset", 'h1234, 9, 7, viol, fin);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/dram_rd_stride.md
# dram_rd_stride

Parametrised single-clock DRAM read engine, successor to the basic DRAM reader. On `go` it fetches `size` output words starting at `start_addr` with a programmable address stride. It unpacks each wide DRAM word into `DATA_IN_WIDTH/OUTPUT_WIDTH` output words and buffers responses in an internal FIFO. It also limits outstanding requests with a credit count, so the FIFO never overflows. It sits between the DRAM controller read port and pipeline stages that consume data with a `valid`/`rd_en` handshake.

## Interface
- `ADDR_WIDTH`, 15, DRAM word address width.
- `SIZE_WIDTH`, 17, width of transfer length in output words.
- `STRIDE_WIDTH`, 8, width of the unsigned address increment.
- `OUTPUT_WIDTH`, 16, output word width.
- `DATA_IN_WIDTH`, 32, DRAM data width. `RATIO = DATA_IN_WIDTH/OUTPUT_WIDTH` must be a power of 2, ≥1.
- `FIFO_DEPTH`, 16, DRAM-word entries, power of 2, ≥2.
- `dram_clk` in 1: the only clock; all logic is on the rising edge.
- `dram_rst` in 1: asynchronous, active-high reset.
- `go` in 1: start pulse, sampled only in IDLE or DONE.
- `start_addr` in ADDR_WIDTH: first DRAM address, captured on go.
- `size` in SIZE_WIDTH: output words to deliver, captured on go.
- `stride` in STRIDE_WIDTH: address increment per DRAM request, captured on go.
- `stall` in 1: blocks assertion of new DRAM requests.
- `rd_en` in 1: consumer pops one output word when `valid`=1.
- `valid` out 1: `data` holds an unconsumed word.
- `data` out OUTPUT_WIDTH: output word.
- `done` out 1: level; all `size` words consumed.
- `busy` out 1: state is ACTIVE.
- `dram_ready` in 1: controller accepts the request this cycle.
- `dram_rd_en` out 1: read request.
- `dram_rd_addr` out ADDR_WIDTH: request address.
- `dram_rd_data` in DATA_IN_WIDTH: response data.
- `dram_rd_valid` in 1: response strobe, in request order.

## Operation
- States are IDLE, ACTIVE and DONE.
- **IDLE/DONE → ACTIVE:** on `go`=1 with `size`≠0.
  - Capture the inputs.
  - Set `req_left = ceil(size/RATIO)` and `out_left = size`.
  - Clear `done`.
- **`go` with `size`=0:** goes straight to DONE; no DRAM requests are issued.
- **`go` while ACTIVE:** ignored.
- **Request address:** the k-th request uses `start_addr + k*stride` mod 2^ADDR_WIDTH. Wrap-around is silent. `stride`=0 re-reads the same address.
- **Issuing a request:** a new request may be asserted when all of the following hold:
  - state is ACTIVE;
  - `req_left`>0;
  - `stall`=0;
  - `credits_used < FIFO_DEPTH`, where `credits_used` = FIFO occupancy + outstanding requests + the asserted request.
- **Holding a request:** once `dram_rd_en`=1, it and `dram_rd_addr` stay stable until `dram_ready`=1, regardless of `stall`.
  - Acceptance is the cycle with `dram_rd_en && dram_ready`.
  - On acceptance, `req_left` decrements and the outstanding count increments.
- **Response:** `dram_rd_valid` writes `dram_rd_data` to the FIFO and decrements the outstanding count.
  - `dram_rd_valid` is ignored when the outstanding count is 0, including stale responses after reset.
- **Unpacker:**
  - Presents FIFO-head slices lowest bits first: slice i = bits [i*OUTPUT_WIDTH +: OUTPUT_WIDTH].
  - A pop (`rd_en && valid`) advances the slice index.
  - The FIFO entry is popped after slice RATIO-1, or after the final needed slice of the transfer.
  - Unused slices of the last DRAM word are discarded.
- **`rd_en` with `valid`=0:** no effect.
- **ACTIVE → DONE:** on the pop that brings `out_left` to 0.
- **Reset:**
  - All outputs go to 0: `valid`, `data`, `done`, `busy`, `dram_rd_en`, `dram_rd_addr`.
  - State goes to IDLE; FIFO and all counters are cleared.
  - Reset mid-transfer abandons the transfer and discards any data in flight.

## Timing
- `go` sampled at edge 0: `busy`=1 and the first `dram_rd_en` may be asserted after edge 0 (cycle 1).
- With `dram_ready`=1, `stall`=0 and credits available, requests are accepted one per cycle.
- Response at edge t gives `valid`=1 from t+1 when the FIFO was empty. FIFO and output are registered; there is no combinational path from `dram_rd_valid` to `valid`.
- A pop at edge t shows the next slice at t+1. Sustained throughput is 1 output word/cycle when data is available.
- `done` rises the cycle after the last pop; `busy` falls in the same cycle.
- Simultaneous FIFO write and pop in the same cycle: occupancy is unchanged, both take effect.
- `stall` acts combinationally only on assertion of a new request. It never drops an asserted request.

## Structure
- **Package `dram_rd_pkg`:** state enum (`ST_IDLE`, `ST_ACTIVE`, `ST_DONE`).
- **Helper `ratio_log2`:** parameter-derived constant, computed in the module.
- **Sub-module `dram_rd_fifo`:** synchronous FWFT FIFO, parametrised width and depth, with `count` output, asynchronous active-high reset.
- **Top module contains:** FSM, address generator, credit counter, unpacker.

## Test plan
- **Basic packed read:** RATIO=2, `start_addr`=0x10, `size`=6, `stride`=1, `dram_ready`=1, 2-cycle response latency, `rd_en`=1 → addresses 0x10,0x11,0x12; output slices in low-then-high order; `done` after the 6th pop.
- **Odd size with stride and wrap:** `size`=5, `stride`=3, `start_addr`=0x7FFE → addresses 0x7FFE, 0x0001, 0x0004; 5 words output; the upper slice of the third word is discarded.
- **Backpressure:** `rd_en`=0 for 100 cycles with FIFO_DEPTH=16 → at most 16 requests accepted; no response lost when `rd_en` resumes.
- **Held request under stall:** `dram_ready`=0 for 5 cycles, then `stall` pulsed → `dram_rd_en`/`dram_rd_addr` stable until accepted; no new request asserted while `stall`=1.
- **Zero size and busy go:** `size`=0 → `done`=1 with no `dram_rd_en`. `go` during ACTIVE → ignored, transfer unchanged.
- **Reset mid-transfer:** `dram_rst` mid-transfer with 3 requests outstanding → outputs 0 and state IDLE; late `dram_rd_valid` pulses ignored; the next `go` delivers correct data.
